// File: rtl/ex_stage.sv
// Execute stage: ALU, operand/write-register muxing, EX/MEM pipeline register,
// and an iterative 32-step multu/divu unit (IDLE -> BUSY -> DONE) owning HI/LO.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ALUOp,
  input  logic        ALUSrc,
  input  logic        RegDst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic [31:0] imm,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  output logic        out_MemRead,
  output logic        out_MemWrite,
  output logic        out_MemtoReg,
  output logic        out_RegWrite,
  output logic [31:0] out_alu,
  output logic [31:0] out_rd2,
  output logic [4:0]  out_wreg,
  output logic        out_zero,
  output logic        stall
);

  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  // state | meaning
  // IDLE  | accept instructions; a multu/divu stalls and is latched on the next edge
  // BUSY  | one multiply/divide iteration per cycle, 32 in total, stall held
  // DONE  | HI/LO valid, stall released, EX/MEM takes the instruction, back to IDLE
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] wa_q, wb_q, dvs_q;
  logic        div_q;
  logic [31:0] hi_q, lo_q;

  logic        mr_q, mw_q, m2r_q, rw_q, zero_q;
  logic [31:0] alu_q, rd2_q;
  logic [4:0]  wreg_q;

  logic [31:0] opb, res;
  logic [4:0]  wreg_d;
  logic        legal, is_md;

  always_comb begin
    opb    = ALUSrc ? imm : rd2;
    wreg_d = RegDst ? rd : rt;
    res    = '0;
    legal  = 1'b1;
    is_md  = 1'b0;
    unique case (ALUOp)
      2'b00: res = rd1 + opb;
      2'b01: res = rd1 - opb;
      2'b11: res = rd1 | opb;
      default: begin
        case (funct)
          F_ADD:   res = rd1 + opb;
          F_SUB:   res = rd1 - opb;
          F_AND:   res = rd1 & opb;
          F_OR:    res = rd1 | opb;
          F_SLT:   res = {31'd0, $signed(rd1) < $signed(opb)};
          F_MFHI:  res = hi_q;
          F_MFLO:  res = lo_q;
          F_MULTU: is_md = 1'b1;
          F_DIVU:  is_md = 1'b1;
          default: legal = 1'b0;
        endcase
      end
    endcase
  end

  assign stall = !rst && ((state_q == IDLE && is_md) || state_q == BUSY);

  // wa holds the running upper half (product high / remainder), wb the lower
  // half (multiplier bits shifting out / quotient bits shifting in).
  logic [32:0] msum, dshift, ddiff;
  logic [31:0] wa_step, wb_step;

  always_comb begin
    msum   = {1'b0, wa_q} + (wb_q[0] ? {1'b0, dvs_q} : 33'd0);
    dshift = {wa_q, wb_q[31]};
    ddiff  = dshift - {1'b0, dvs_q};
    if (div_q) begin
      wa_step = ddiff[32] ? dshift[31:0] : ddiff[31:0];
      wb_step = {wb_q[30:0], ~ddiff[32]};
    end else begin
      wa_step = msum[32:1];
      wb_step = {msum[0], wb_q[31:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wa_q    <= '0;
      wb_q    <= '0;
      dvs_q   <= '0;
      div_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      rw_q    <= 1'b0;
      zero_q  <= 1'b0;
      alu_q   <= '0;
      rd2_q   <= '0;
      wreg_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (is_md) begin
          wa_q    <= '0;
          wb_q    <= rd1;
          dvs_q   <= rd2;
          div_q   <= (funct == F_DIVU);
          cnt_q   <= '0;
          state_q <= BUSY;
        end
        BUSY: begin
          wa_q  <= wa_step;
          wb_q  <= wb_step;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            hi_q    <= wa_step;
            lo_q    <= wb_step;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (stall) begin
        mr_q  <= 1'b0;
        mw_q  <= 1'b0;
        m2r_q <= 1'b0;
        rw_q  <= 1'b0;
      end else begin
        mr_q   <= MemRead & ~is_md;
        mw_q   <= MemWrite & ~is_md;
        m2r_q  <= MemtoReg;
        rw_q   <= RegWrite & legal & ~is_md;
        alu_q  <= res;
        rd2_q  <= rd2;
        wreg_q <= wreg_d;
        zero_q <= (res == 32'd0);
      end
    end
  end

  assign out_MemRead  = mr_q;
  assign out_MemWrite = mw_q;
  assign out_MemtoReg = m2r_q;
  assign out_RegWrite = rw_q;
  assign out_alu      = alu_q;
  assign out_rd2      = rd2_q;
  assign out_wreg     = wreg_q;
  assign out_zero     = zero_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expected EX/MEM contents are queued when an
// instruction is driven and compared after the capturing edge.
module tb_ex_stage;

  logic        clk, rst;
  logic [1:0]  ALUOp;
  logic        ALUSrc, RegDst, MemRead, MemWrite, MemtoReg, RegWrite;
  logic [31:0] rd1, rd2, imm;
  logic [4:0]  rt, rd;
  logic [5:0]  funct;
  logic        out_MemRead, out_MemWrite, out_MemtoReg, out_RegWrite;
  logic [31:0] out_alu, out_rd2;
  logic [4:0]  out_wreg;
  logic        out_zero, stall;

  ex_stage dut (
    .clk(clk), .rst(rst), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .RegDst(RegDst),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .rd1(rd1), .rd2(rd2), .imm(imm), .rt(rt), .rd(rd), .funct(funct),
    .out_MemRead(out_MemRead), .out_MemWrite(out_MemWrite), .out_MemtoReg(out_MemtoReg),
    .out_RegWrite(out_RegWrite), .out_alu(out_alu), .out_rd2(out_rd2),
    .out_wreg(out_wreg), .out_zero(out_zero), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  aluop;
    logic        alusrc, regdst, mr, mw, m2r, rw;
    logic [31:0] a, b, imm;
    logic [4:0]  rt, rd;
    logic [5:0]  funct;
  } ins_t;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [4:0]  wreg;
    logic        zero;
    logic [3:0]  ctl;   // {MemRead, MemWrite, MemtoReg, RegWrite}
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] hi_m = 0, lo_m = 0;

  function automatic ins_t mk(input logic [1:0] aluop, input logic [5:0] fn,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] im, input logic alusrc,
                              input logic regdst, input logic [4:0] rtv,
                              input logic [4:0] rdv, input logic [3:0] ctl);
    ins_t i;
    i.aluop = aluop; i.funct = fn; i.a = a; i.b = b; i.imm = im;
    i.alusrc = alusrc; i.regdst = regdst; i.rt = rtv; i.rd = rdv;
    {i.mr, i.mw, i.m2r, i.rw} = ctl;
    return i;
  endfunction

  function automatic ins_t rtype(input logic [5:0] fn, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rdv);
    return mk(2'b10, fn, a, b, 32'h0, 1'b0, 1'b1, 5'd3, rdv, 4'b0001);
  endfunction

  function automatic exp_t model(input ins_t i);
    exp_t        e;
    logic [31:0] b, r;
    logic        mr, mw, rw;
    b  = i.alusrc ? i.imm : i.b;
    mr = i.mr; mw = i.mw; rw = i.rw;
    r  = 32'h0;
    case (i.aluop)
      2'b00: r = i.a + b;
      2'b01: r = i.a - b;
      2'b11: r = i.a | b;
      default: case (i.funct)
        6'h20: r = i.a + b;
        6'h22: r = i.a - b;
        6'h24: r = i.a & b;
        6'h25: r = i.a | b;
        6'h2A: r = ($signed(i.a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h10: r = hi_m;
        6'h12: r = lo_m;
        6'h19, 6'h1B: begin r = 32'h0; mr = 1'b0; mw = 1'b0; rw = 1'b0; end
        default: rw = 1'b0;
      endcase
    endcase
    e.alu  = r;
    e.rd2  = i.b;
    e.wreg = i.regdst ? i.rd : i.rt;
    e.zero = (r == 32'h0);
    e.ctl  = {mr, mw, i.m2r, rw};
    return e;
  endfunction

  task automatic drive(input ins_t i);
    ALUOp = i.aluop; ALUSrc = i.alusrc; RegDst = i.regdst;
    MemRead = i.mr; MemWrite = i.mw; MemtoReg = i.m2r; RegWrite = i.rw;
    rd1 = i.a; rd2 = i.b; imm = i.imm; rt = i.rt; rd = i.rd; funct = i.funct;
  endtask

  task automatic check_pop(input string name);
    exp_t e, got;
    got = {out_alu, out_rd2, out_wreg, out_zero,
           out_MemRead, out_MemWrite, out_MemtoReg, out_RegWrite};
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s: output %h with empty scoreboard", name, got);
    end else begin
      e = sb.pop_front();
      if (got !== e) begin
        n_err++;
        $display("FAIL %s: got alu=%h rd2=%h wreg=%0d zero=%b ctl=%b, want alu=%h rd2=%h wreg=%0d zero=%b ctl=%b",
                 name, got.alu, got.rd2, got.wreg, got.zero, got.ctl,
                 e.alu, e.rd2, e.wreg, e.zero, e.ctl);
      end
    end
  endtask

  task automatic issue(input ins_t i, input string name);
    drive(i);
    sb.push_back(model(i));
    @(posedge clk);
    @(negedge clk);
    check_pop(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(rtype(6'h19, 32'h5, 32'h6, 5'd0));
    @(negedge clk); @(negedge clk);
    n_vec++;
    if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_vec++;
    if ({out_alu, out_rd2, out_wreg, out_zero, out_MemRead, out_MemWrite, out_MemtoReg, out_RegWrite} !== '0) begin
      n_err++;
      $display("FAIL reset_outs: got alu=%h rd2=%h wreg=%0d want all 0", out_alu, out_rd2, out_wreg);
    end
    drive(mk(2'b00, 6'h0, 0, 0, 0, 1'b0, 1'b0, 5'd0, 5'd0, 4'b0000));
    rst = 1'b0;
  endtask

  task automatic test_alu();
    issue(rtype(6'h20, 32'h7FFFFFFF, 32'h1, 5'd5), "add_ovf");
    issue(mk(2'b00, 6'h0, 32'h100, 32'hDEAD, 32'hFFFFFFFC, 1'b1, 1'b0, 5'd8, 5'd9, 4'b1000), "lw_addr");
    issue(mk(2'b01, 6'h0, 32'h0, 32'h1, 32'h0, 1'b0, 1'b0, 5'd2, 5'd4, 4'b0000), "sub_wrap");
    issue(mk(2'b11, 6'h0, 32'hF0F0_0000, 32'h0, 32'h0000_1234, 1'b1, 1'b0, 5'd7, 5'd1, 4'b0001), "ori");
    issue(rtype(6'h22, 32'h5, 32'h5, 5'd6), "sub_zero");
    issue(rtype(6'h24, 32'hFF00FF00, 32'h0FF00FF0, 5'd10), "and");
    issue(rtype(6'h25, 32'hFF00FF00, 32'h0FF00FF0, 5'd11), "or");
    issue(rtype(6'h2A, 32'hFFFFFFFF, 32'h0, 5'd12), "slt_neg");
    issue(rtype(6'h2A, 32'h1, 32'hFFFFFFFF, 5'd13), "slt_pos");
    issue(rtype(6'h3F, 32'h1234, 32'h5678, 5'd14), "illegal");
    issue(mk(2'b00, 6'h0, 32'h40, 32'hCAFEF00D, 32'h8, 1'b1, 1'b0, 5'd3, 5'd0, 4'b0100), "sw");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 24; k++) begin
      logic [5:0] fns [7];
      logic [5:0] f;
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h10, 6'h3F};
      f   = fns[$urandom_range(0, 6)];
      if (k % 3 == 0)
        issue(mk(2'($urandom_range(0, 3) == 2 ? 0 : $urandom_range(0, 3)), 6'h0, $urandom, $urandom,
                 $urandom, 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 4'($urandom)), "b2b_i");
      else
        issue(rtype(f, $urandom, $urandom, 5'($urandom)), "b2b_r");
    end
  endtask

  task automatic test_md(input ins_t i, input string name);
    int      cnt;
    logic [63:0] p;
    drive(i);
    #1;
    cnt = 0;
    while (stall === 1'b1 && cnt < 60) begin
      @(negedge clk);
      cnt++;
      n_vec++;
      if ({out_MemRead, out_MemWrite, out_MemtoReg, out_RegWrite} !== 4'b0000) begin
        n_err++;
        $display("FAIL %s_bubble: cycle %0d ctl=%b want 0000", name, cnt,
                 {out_MemRead, out_MemWrite, out_MemtoReg, out_RegWrite});
      end
    end
    n_vec++;
    if (cnt != 33) begin n_err++; $display("FAIL %s_stall_len: got %0d want 33", name, cnt); end
    sb.push_back(model(i));
    if (i.funct == 6'h19) begin
      p = {32'h0, i.a} * {32'h0, i.b};
      hi_m = p[63:32]; lo_m = p[31:0];
    end else if (i.b == 0) begin
      hi_m = i.a; lo_m = 32'hFFFFFFFF;
    end else begin
      hi_m = i.a % i.b; lo_m = i.a / i.b;
    end
    @(posedge clk);
    #1 drive(rtype(6'h10, 32'h0, 32'h0, 5'd20));
    @(negedge clk);
    check_pop({name, "_wb"});
    n_vec++;
    if (stall !== 1'b0) begin n_err++; $display("FAIL %s_reissue: stall got %b want 0", name, stall); end
    issue(rtype(6'h10, 32'h0, 32'h0, 5'd20), {name, "_mfhi"});
    issue(rtype(6'h12, 32'h0, 32'h0, 5'd21), {name, "_mflo"});
  endtask

  task automatic test_muldiv();
    test_md(rtype(6'h19, 32'hFFFFFFFF, 32'h2, 5'd0), "multu");
    test_md(rtype(6'h1B, 32'd100, 32'd7, 5'd0), "divu");
    test_md(rtype(6'h1B, 32'd100, 32'd0, 5'd0), "divu0");
    test_md(rtype(6'h19, $urandom, $urandom, 5'd0), "multu_rnd");
    test_md(rtype(6'h1B, $urandom, 32'($urandom_range(1, 65535)), 5'd0), "divu_rnd");
    test_md(rtype(6'h1B, 32'd3, 32'hFFFFFFF0, 5'd0), "divu_small");
  endtask

  task automatic test_reset_busy();
    issue(rtype(6'h20, 32'd5, 32'd6, 5'd9), "pre_rst_add");
    drive(rtype(6'h19, 32'h12345678, 32'h9ABCDEF0, 5'd0));
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    hi_m = 0; lo_m = 0;
    n_vec++;
    if (stall !== 1'b0) begin n_err++; $display("FAIL rst_busy_stall: got %b want 0", stall); end
    n_vec++;
    if ({out_alu, out_rd2, out_wreg, out_zero, out_MemRead, out_MemWrite, out_MemtoReg, out_RegWrite} !== '0) begin
      n_err++;
      $display("FAIL rst_busy_outs: got alu=%h rd2=%h wreg=%0d rw=%b want all 0",
               out_alu, out_rd2, out_wreg, out_RegWrite);
    end
    drive(rtype(6'h20, 32'd40, 32'd2, 5'd15));
    @(negedge clk);
    rst = 1'b0;
    issue(rtype(6'h20, 32'd40, 32'd2, 5'd15), "post_rst_add");
    issue(rtype(6'h10, 32'h0, 32'h0, 5'd16), "post_rst_mfhi");
    issue(rtype(6'h12, 32'h0, 32'h0, 5'd17), "post_rst_mflo");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_muldiv();
    test_reset_busy();
    test_alu();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL use one clock and asynchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 ALUOp  in  2  from ID/EX: 00 add, 01 sub, 10 R-type per funct, 11 or.
REQ-005 ALUSrc, RegDst  in  1 each  operand-B select (1 = imm) and write-register select (1 = rd, 0 = rt).
REQ-006 MemRead, MemWrite, MemtoReg, RegWrite  in  1 each  control passed through to MEM/WB.
REQ-007 rd1, rd2, imm  in  32 each  operand A, operand B / store data, sign-extended immediate.
REQ-008 rt, rd  in  5 each; funct  in  6  R-type function field.
REQ-009 out_MemRead, out_MemWrite, out_MemtoReg, out_RegWrite  out  1 each  registered EX/MEM control.
REQ-010 out_alu, out_rd2  out  32 each  registered ALU result and store data.
REQ-011 out_wreg  out  5; out_zero  out  1  registered destination register and (result == 0) flag.
REQ-012 stall  out  1  combinational request for upstream stages to hold; the ID/EX inputs SHALL stay stable while stall=1.

Function
REQ-013 Operand B SHALL be imm when ALUSrc=1, otherwise rd2; the write register SHALL be rd when RegDst=1, otherwise rt.
REQ-014 R-type funct SHALL decode as: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed slt (result 1/0), 0x10 mfhi, 0x12 mflo, 0x19 multu, 0x1B divu.
REQ-015 Add and sub SHALL wrap modulo 2^32 with no overflow trap.
REQ-016 An unlisted funct SHALL give result 0 with RegWrite forced to 0 in EX/MEM.
REQ-017 Single-cycle ops SHALL have a latency of 1: the EX/MEM outputs update on the first rising edge after the inputs are presented.
REQ-018 The mult/div unit SHALL implement an FSM with states IDLE, BUSY and DONE, plus a 5-bit iteration counter.
REQ-019 IDLE with multu/divu presented: stall=1; on the next edge, latch rd1/rd2 unsigned, counter=0, go to BUSY.
REQ-020 BUSY: stall=1; one shift-add (multu) or restoring-subtract (divu) step per cycle; after the 32nd step, write HI/LO and go to DONE.
REQ-021 DONE: stall=0; on the next edge, EX/MEM captures the instruction and the FSM returns to IDLE unconditionally, with no re-issue.
REQ-022 A multu/divu SHALL therefore hold stall=1 for exactly 33 consecutive cycles.
REQ-023 multu SHALL set {HI,LO} = rd1*rd2 as a 64-bit unsigned product.
REQ-024 divu SHALL set LO = quotient and HI = remainder.
REQ-025 divu by zero SHALL set LO = 0xFFFFFFFF and HI = rd1, with the same 33-cycle timing.
REQ-026 multu and divu SHALL reach EX/MEM with out_RegWrite, out_MemRead and out_MemWrite all 0.
REQ-027 While stall=1, each edge SHALL load a bubble into EX/MEM: all four control outputs 0, data outputs don't-care but held.
REQ-028 mfhi/mflo issued directly after a multu/divu SHALL return the new HI/LO values, since HI/LO update before DONE.
REQ-029 HI and LO SHALL change only at BUSY->DONE.

Reset
REQ-030 Asserting rst SHALL immediately clear all out_* registers, HI, LO and the counter to 0, and force the FSM to IDLE.
REQ-031 While rst=1, stall SHALL be 0.
REQ-032 Reset during BUSY SHALL abort the operation, leaving HI/LO = 0.
REQ-033 After rst is released, the first edge SHALL behave as a normal IDLE edge.

Verification
REQ-034 ALUOp=10, funct=0x20, rd1=0x7FFFFFFF, rd2=1, RegDst=1, rd=5 -> next edge: out_alu=0x80000000, out_wreg=5, out_zero=0.
REQ-035 ALUOp=00, ALUSrc=1, rd1=0x100, imm=0xFFFFFFFC, MemRead=1, rt=8 -> out_alu=0xFC, out_MemRead=1, out_wreg=8.
REQ-036 multu with rd1=0xFFFFFFFF, rd2=2 -> stall high 33 cycles with bubbles in EX/MEM; then mfhi -> out_alu=1, and mflo -> out_alu=0xFFFFFFFE.
REQ-037 divu with rd1=100, rd2=7 -> LO=14, HI=2; divu with rd2=0 -> LO=0xFFFFFFFF, HI=100.
REQ-038 rst pulsed at BUSY cycle 10 -> outputs, HI and LO become 0 immediately, stall=0, and a following add completes in 1 cycle.
REQ-039 slt with rd1=0xFFFFFFFF, rd2=0 -> out_alu=1; funct=0x3F -> out_alu=0 and out_RegWrite=0.
